// File: rtl/score_pkg.sv
// Shared types and constants for the score accumulator slice.
package score_pkg;

  localparam int unsigned SCORE_W = 16;
  localparam int unsigned SUM_W   = SCORE_W + 1;
  localparam int unsigned COMBO_W = 3;
  localparam int unsigned TIMER_W = 7;

  localparam int unsigned SCORE_MAX    = 9999;
  localparam int unsigned PTS_ENEMY    = 100;
  localparam int unsigned PTS_BRICK    = 10;
  localparam int unsigned PTS_BONUS    = 50;
  localparam int unsigned COMBO_WINDOW = 64;
  localparam int unsigned COMBO_MAX    = 4;

  typedef enum logic [1:0] {
    IDLE,
    PLAYING,
    FREEZE
  } score_state_t;

  // Clamp a 17-bit sum to the 4-digit ceiling.
  function automatic logic [SCORE_W-1:0] sat_score(input logic [SUM_W-1:0] sum);
    if (sum > SUM_W'(SCORE_MAX)) begin
      return SCORE_W'(SCORE_MAX);
    end
    return sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/combo_timer.sv
// Enemy-kill combo multiplier and its frame-based expiry timer.
// combo_next_o is the multiplier after this cycle's kill update, so the
// adder can weight a kill with the combo it just earned.
module combo_timer
  import score_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               tick_i,
  input  logic               enemy_hit_i,
  output logic [COMBO_W-1:0] combo_o,
  output logic [COMBO_W-1:0] combo_next_o
);

  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  // Next combo/timer: clear beats a kill, a kill beats a frame tick.
  always_comb begin
    combo_d = combo_q;
    timer_d = timer_q;
    if (clear_i) begin
      combo_d = COMBO_W'(1);
      timer_d = '0;
    end else if (enemy_hit_i) begin
      if (timer_q != '0) begin
        combo_d = (combo_q >= COMBO_W'(COMBO_MAX)) ? COMBO_W'(COMBO_MAX)
                                                   : combo_q + COMBO_W'(1);
      end else begin
        combo_d = COMBO_W'(1);
      end
      timer_d = TIMER_W'(COMBO_WINDOW);
    end else if (tick_i && (timer_q != '0)) begin
      timer_d = timer_q - TIMER_W'(1);
      // Window expires on this tick: drop the multiplier immediately.
      if (timer_q == TIMER_W'(1)) begin
        combo_d = COMBO_W'(1);
      end
    end
  end

  // Combo/timer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      combo_q <= COMBO_W'(1);
      timer_q <= '0;
    end else begin
      combo_q <= combo_d;
      timer_q <= timer_d;
    end
  end

  assign combo_o      = combo_q;
  assign combo_next_o = combo_d;

endmodule

// File: rtl/score_accumulator.sv
// In-game score accumulator: saturating adder, game FSM and final-score latch.
// Optional feature macro HIGH_SCORE_EN: keeps the best final score since reset;
// when undefined, high_score is tied to 0.
module score_accumulator
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               game_start,
  input  logic               game_over,
  input  logic               enemy_hit,
  input  logic               brick_hit,
  input  logic               bonus_hit,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] final_score,
  output logic               final_valid,
  output logic [COMBO_W-1:0] combo,
  output logic [SCORE_W-1:0] high_score
);

  score_state_t       state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] final_q, final_d;
  logic [COMBO_W-1:0] combo_next;
  logic [SUM_W-1:0]   delta;
  logic [SUM_W-1:0]   sum;
  logic [SCORE_W-1:0] sat;
  logic               playing;
  logic               kill;
  logic               latch;

  assign playing = (state_q == PLAYING);
  // Kills outside PLAYING must not touch the combo.
  assign kill    = enemy_hit & playing;
  assign latch   = playing & game_over & ~game_start;

  combo_timer u_combo_timer (
    .clk_i        (clk),
    .rst_i        (reset),
    .clear_i      (game_start),
    .tick_i       (startOfFrame),
    .enemy_hit_i  (kill),
    .combo_o      (combo),
    .combo_next_o (combo_next)
  );

  // Points earned this cycle; all simultaneous hits count.
  always_comb begin
    delta = '0;
    if (enemy_hit) begin
      delta = delta + SUM_W'(PTS_ENEMY) * {{(SUM_W - COMBO_W){1'b0}}, combo_next};
    end
    if (brick_hit) begin
      delta = delta + SUM_W'(PTS_BRICK);
    end
    if (bonus_hit) begin
      delta = delta + SUM_W'(PTS_BONUS);
    end
  end

  assign sum = {1'b0, score_q} + delta;
  assign sat = sat_score(sum);

  // FSM next state and score/final datapath; game_start overrides everything.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    final_d = final_q;
    if (game_start) begin
      state_d = PLAYING;
      score_d = '0;
    end else if (playing) begin
      score_d = sat;
      if (game_over) begin
        state_d = FREEZE;
        final_d = sat;
      end
    end
  end

  // State, live score and final score registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      score_q <= '0;
      final_q <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      final_q <= final_d;
    end
  end

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_q;

  // Best latched final score; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      high_q <= '0;
    end else if (latch && (sat > high_q)) begin
      high_q <= sat;
    end
  end

  assign high_score = high_q;
`else
  logic unused_latch;
  assign unused_latch = latch;
  assign high_score   = '0;
`endif

  assign score       = score_q;
  assign final_score = final_q;
  assign final_valid = (state_q == FREEZE);

endmodule

// File: tb/tb_score_accumulator.sv
// Scoreboard bench for score_accumulator: expected outputs are queued as each
// stimulus cycle is driven and compared once the DUT has registered it.
module tb_score_accumulator;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, game_start, game_over;
  logic        enemy_hit, brick_hit, bonus_hit;
  logic [15:0] score, final_score, high_score;
  logic        final_valid;
  logic [2:0]  combo;

  always #5 clk = ~clk;

  score_accumulator dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .game_start   (game_start),
    .game_over    (game_over),
    .enemy_hit    (enemy_hit),
    .brick_hit    (brick_hit),
    .bonus_hit    (bonus_hit),
    .score        (score),
    .final_score  (final_score),
    .final_valid  (final_valid),
    .combo        (combo),
    .high_score   (high_score)
  );

`ifdef HIGH_SCORE_EN
  localparam bit HsEn = 1'b1;
`else
  localparam bit HsEn = 1'b0;
`endif

  // Stimulus bits: {startOfFrame, game_start, game_over, enemy_hit, brick_hit, bonus_hit}
  localparam logic [5:0] SOF = 6'b100000;
  localparam logic [5:0] GS  = 6'b010000;
  localparam logic [5:0] GO  = 6'b001000;
  localparam logic [5:0] EN  = 6'b000100;
  localparam logic [5:0] BR  = 6'b000010;
  localparam logic [5:0] BO  = 6'b000001;
  localparam logic [5:0] NOP = 6'b000000;

  typedef struct packed {
    logic [15:0] score;
    logic [15:0] fin;
    logic        valid;
    logic [2:0]  combo;
    logic [15:0] high;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_final = 0;
  int   cur_high = 0;

  function automatic out_t mk(input int s, input int f, input bit v, input int c, input int h);
    out_t o;
    o.score = 16'(s);
    o.fin   = 16'(f);
    o.valid = v;
    o.combo = 3'(c);
    o.high  = HsEn ? 16'(h) : 16'd0;
    return o;
  endfunction

  function automatic out_t observed();
    out_t o;
    o.score = score;
    o.fin   = final_score;
    o.valid = final_valid;
    o.combo = combo;
    o.high  = high_score;
    return o;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("score=%0d final=%0d valid=%0b combo=%0d high=%0d",
                     o.score, o.fin, o.valid, o.combo, o.high);
  endfunction

  task automatic cycle(input logic rst, input logic [5:0] s);
    reset = rst;
    {startOfFrame, game_start, game_over, enemy_hit, brick_hit, bonus_hit} = s;
    @(posedge clk);
    #1;
    reset = 1'b0;
    {startOfFrame, game_start, game_over, enemy_hit, brick_hit, bonus_hit} = NOP;
  endtask

  task automatic test_reset();
    logic [5:0] st[$];
    logic       rs[$];
    out_t       ex[$];
    out_t       o, e;
    // Hits during reset, then hits and game_over in IDLE are all ignored.
    rs.push_back(1'b1); st.push_back(EN | BR | BO); ex.push_back(mk(0, 0, 0, 1, 0));
    rs.push_back(1'b1); st.push_back(NOP);          ex.push_back(mk(0, 0, 0, 1, 0));
    rs.push_back(1'b0); st.push_back(BR);           ex.push_back(mk(0, 0, 0, 1, 0));
    rs.push_back(1'b0); st.push_back(GO);           ex.push_back(mk(0, 0, 0, 1, 0));
    rs.push_back(1'b0); st.push_back(EN | BO);      ex.push_back(mk(0, 0, 0, 1, 0));
    foreach (st[i]) begin
      exp_q.push_back(ex[i]);
      cycle(rs[i], st[i]);
      o = observed();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset[%0d] got %s expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_brick();
    logic [5:0] st[$];
    out_t       ex[$];
    out_t       o, e;
    st.push_back(GS); ex.push_back(mk(0, cur_final, 0, 1, cur_high));
    for (int k = 1; k <= 3; k++) begin
      st.push_back(BR); ex.push_back(mk(10 * k, cur_final, 0, 1, cur_high));
    end
    foreach (st[i]) begin
      exp_q.push_back(ex[i]);
      cycle(1'b0, st[i]);
      o = observed();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL brick[%0d] got %s expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_combo();
    logic [5:0] st[$];
    out_t       ex[$];
    out_t       o, e;
    st.push_back(GS); ex.push_back(mk(0, cur_final, 0, 1, cur_high));
    st.push_back(EN); ex.push_back(mk(100, cur_final, 0, 1, cur_high));
    for (int k = 0; k < 10; k++) begin
      st.push_back(SOF); ex.push_back(mk(100, cur_final, 0, 1, cur_high));
    end
    st.push_back(EN); ex.push_back(mk(300, cur_final, 0, 2, cur_high));
    st.push_back(EN); ex.push_back(mk(600, cur_final, 0, 3, cur_high));
    foreach (st[i]) begin
      exp_q.push_back(ex[i]);
      cycle(1'b0, st[i]);
      o = observed();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL combo[%0d] got %s expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_window();
    logic [5:0] st[$];
    out_t       ex[$];
    out_t       o, e;
    st.push_back(GS); ex.push_back(mk(0, cur_final, 0, 1, cur_high));
    st.push_back(EN); ex.push_back(mk(100, cur_final, 0, 1, cur_high));
    st.push_back(EN); ex.push_back(mk(300, cur_final, 0, 2, cur_high));
    // Combo holds for 63 frames and expires on the 64th.
    for (int k = 1; k <= 64; k++) begin
      st.push_back(SOF); ex.push_back(mk(300, cur_final, 0, (k < 64) ? 2 : 1, cur_high));
    end
    st.push_back(EN); ex.push_back(mk(400, cur_final, 0, 1, cur_high));
    foreach (st[i]) begin
      exp_q.push_back(ex[i]);
      cycle(1'b0, st[i]);
      o = observed();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL window[%0d] got %s expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_saturate();
    logic [5:0] st[$];
    out_t       ex[$];
    out_t       o, e;
    int         sc;
    int         c;
    st.push_back(GS); ex.push_back(mk(0, cur_final, 0, 1, cur_high));
    sc = 0;
    for (int k = 1; k <= 26; k++) begin
      c  = (k < 4) ? k : 4;
      sc = sc + 100 * c;
      st.push_back(EN); ex.push_back(mk(sc, cur_final, 0, c, cur_high));
    end
    for (int k = 0; k < 3; k++) begin
      sc = sc + 50;
      st.push_back(BO); ex.push_back(mk(sc, cur_final, 0, 4, cur_high));
    end
    for (int k = 0; k < 4; k++) begin
      sc = sc + 10;
      st.push_back(BR); ex.push_back(mk(sc, cur_final, 0, 4, cur_high));
    end
    // sc is now 9990; +460 must clamp, and further hits stay clamped.
    st.push_back(EN | BR | BO); ex.push_back(mk(9999, cur_final, 0, 4, cur_high));
    st.push_back(BR);           ex.push_back(mk(9999, cur_final, 0, 4, cur_high));
    st.push_back(BR | BO);      ex.push_back(mk(9999, cur_final, 0, 4, cur_high));
    foreach (st[i]) begin
      exp_q.push_back(ex[i]);
      cycle(1'b0, st[i]);
      o = observed();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL saturate[%0d] got %s expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_game_over();
    logic [5:0] st[$];
    out_t       ex[$];
    out_t       o, e;
    st.push_back(GS); ex.push_back(mk(0, cur_final, 0, 1, cur_high));
    for (int k = 1; k <= 9; k++) begin
      st.push_back(BO); ex.push_back(mk(50 * k, cur_final, 0, 1, cur_high));
    end
    cur_final = 500;
    cur_high  = 500;
    st.push_back(GO | BO); ex.push_back(mk(500, 500, 1, 1, 500));
    st.push_back(BR);      ex.push_back(mk(500, 500, 1, 1, 500));
    st.push_back(EN);      ex.push_back(mk(500, 500, 1, 1, 500));
    st.push_back(GO | BO); ex.push_back(mk(500, 500, 1, 1, 500));
    st.push_back(GS);      ex.push_back(mk(0, 500, 0, 1, 500));
    for (int k = 1; k <= 4; k++) begin
      st.push_back(BO); ex.push_back(mk(50 * k, 500, 0, 1, 500));
    end
    st.push_back(GO); ex.push_back(mk(200, 200, 1, 1, 500));
    cur_final = 200;
    foreach (st[i]) begin
      exp_q.push_back(ex[i]);
      cycle(1'b0, st[i]);
      o = observed();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL game_over[%0d] got %s expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_start_wins();
    logic [5:0] st[$];
    out_t       ex[$];
    out_t       o, e;
    st.push_back(GS);           ex.push_back(mk(0, 200, 0, 1, 500));
    st.push_back(BR);           ex.push_back(mk(10, 200, 0, 1, 500));
    st.push_back(GS | GO | BR); ex.push_back(mk(0, 200, 0, 1, 500));
    st.push_back(BR);           ex.push_back(mk(10, 200, 0, 1, 500));
    st.push_back(GO);           ex.push_back(mk(10, 10, 1, 1, 500));
    cur_final = 10;
    foreach (st[i]) begin
      exp_q.push_back(ex[i]);
      cycle(1'b0, st[i]);
      o = observed();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL start_wins[%0d] got %s expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] st[$];
    logic       rs[$];
    out_t       ex[$];
    out_t       o, e;
    rs.push_back(1'b0); st.push_back(GS); ex.push_back(mk(0, 10, 0, 1, 500));
    for (int k = 1; k <= 14; k++) begin
      rs.push_back(1'b0); st.push_back(BO); ex.push_back(mk(50 * k, 10, 0, 1, 500));
    end
    rs.push_back(1'b0); st.push_back(EN); ex.push_back(mk(800, 10, 0, 1, 500));
    rs.push_back(1'b1); st.push_back(EN | BR); ex.push_back(mk(0, 0, 0, 1, 0));
    rs.push_back(1'b0); st.push_back(BR);      ex.push_back(mk(0, 0, 0, 1, 0));
    rs.push_back(1'b0); st.push_back(EN);      ex.push_back(mk(0, 0, 0, 1, 0));
    rs.push_back(1'b0); st.push_back(GO | BO); ex.push_back(mk(0, 0, 0, 1, 0));
    cur_final = 0;
    cur_high  = 0;
    foreach (st[i]) begin
      exp_q.push_back(ex[i]);
      cycle(rs[i], st[i]);
      o = observed();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid[%0d] got %s expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    {startOfFrame, game_start, game_over, enemy_hit, brick_hit, bonus_hit} = NOP;
    test_reset();
    test_brick();
    test_combo();
    test_window();
    test_saturate();
    test_game_over();
    test_start_wins();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
